// File: rtl/riscv_pkg.sv
// RV32I opcode constants, immediate-format enum and opcode-to-format lookup.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U,
    FMT_BAD
  } imm_fmt_e;

  // JALR and SYSTEM/FENCE are deliberately not encodable on this path.
  function automatic imm_fmt_e opcode_fmt(input logic [6:0] op);
    imm_fmt_e fmt;
    case (op)
      OP_I_TYPE, OP_LOAD: fmt = FMT_I;
      OP_STORE:           fmt = FMT_S;
      OP_BRANCH:          fmt = FMT_B;
      OP_JAL:             fmt = FMT_J;
      OP_LUI, OP_AUIPC:   fmt = FMT_U;
      OP_R_TYPE:          fmt = FMT_R;
      default:            fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I packer: picks the format from the opcode, range-checks
// the decoded immediate and scatters it back into instruction bit positions.
module inst_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_legal
);

  imm_fmt_e           w_fmt;
  logic signed [31:0] w_simm;

  assign w_fmt  = opcode_fmt(i_opcode);
  assign w_simm = $signed(i_imm);

  // Legality check and bit packing for the selected format
  always_comb begin
    o_instr = 32'h0;
    o_legal = 1'b0;
    case (w_fmt)
      FMT_I: begin
        o_legal = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
        o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_S: begin
        o_legal = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
        o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      end
      FMT_B: begin
        o_legal = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094) && !i_imm[0];
        o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                   i_imm[4:1], i_imm[11], i_opcode};
      end
      FMT_J: begin
        o_legal = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574) && !i_imm[0];
        o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      end
      FMT_U: begin
        o_legal = (i_imm[11:0] == 12'h000);
        o_instr = {i_imm[31:12], i_rd, i_opcode};
      end
      FMT_R: begin
        o_legal = 1'b1;
        o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      default: begin
        o_legal = 1'b0;
        o_instr = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder for the program-load path: valid/ready input,
// 2-entry output buffer, auto-incrementing byte address, illegal-request counter.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  logic [31:0] w_instr;
  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  logic [31:0] r_instr [0:1];
  logic [31:0] r_addr  [0:1];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [31:0] r_addr_cnt;
  logic        r_err_pulse;
  logic [15:0] r_err_count;

  inst_pack u_pack (
    .i_opcode (in_opcode),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_funct3 (in_funct3),
    .i_funct7 (in_funct7),
    .i_imm    (in_imm),
    .o_instr  (w_instr),
    .o_legal  (w_legal)
  );

  // Input readiness ignores out_ready on purpose: a full buffer blocks input
  assign in_ready  = (r_count < 2'd2) && !restart;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_legal;
  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid && out_ready;

  assign out_instr = r_instr[r_rd_ptr];
  assign out_addr  = r_addr[r_rd_ptr];
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

  // Buffer storage: capture the packed word and its address on push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr[0] <= 32'h0;
      r_instr[1] <= 32'h0;
      r_addr[0]  <= 32'h0;
      r_addr[1]  <= 32'h0;
    end else if (restart) begin
      r_instr[0] <= 32'h0;
      r_instr[1] <= 32'h0;
      r_addr[0]  <= 32'h0;
      r_addr[1]  <= 32'h0;
    end else if (w_push) begin
      r_instr[r_wr_ptr] <= w_instr;
      r_addr[r_wr_ptr]  <= r_addr_cnt;
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (restart) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Address counter: advances by one word per legal push, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_cnt <= BASE_ADDR;
    end else if (restart) begin
      r_addr_cnt <= BASE_ADDR;
    end else if (w_push) begin
      r_addr_cnt <= r_addr_cnt + 32'd4;
    end
  end

  // Error pulse and saturating count; restart keeps the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_pulse <= 1'b0;
      r_err_count <= 16'h0;
    end else if (restart) begin
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_err_count != 16'hFFFF))
        r_err_count <= r_err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: two instances share stimulus, one at
// BASE_ADDR=0 and one at BASE_ADDR=0xFFFF_FFFC to exercise address wrap.
module tb_inst_encoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  in_opcode = 7'h0;
  logic [4:0]  in_rd = 5'h0;
  logic [4:0]  in_rs1 = 5'h0;
  logic [4:0]  in_rs2 = 5'h0;
  logic [2:0]  in_funct3 = 3'h0;
  logic [6:0]  in_funct7 = 7'h0;
  logic [31:0] in_imm = 32'h0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, err_pulse;
  logic [31:0] out_instr, out_addr;
  logic [15:0] err_count;

  logic        w_in_ready, w_out_valid, w_err_pulse;
  logic [31:0] w_out_instr, w_out_addr;
  logic [15:0] w_err_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp_waddr = 32'hFFFF_FFFC;
  logic [15:0] exp_errs = 16'h0;

  always #5 clk = ~clk;

  inst_encoder #(.BASE_ADDR(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  inst_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .restart(restart),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_instr(w_out_instr), .out_addr(w_out_addr),
    .err_pulse(w_err_pulse), .err_count(w_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid  = 1'b1;
    #1;
  endtask

  task automatic send_ok(input string tag, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm,
                         input logic [31:0] exp_instr);
    put(op, rd, rs1, rs2, f3, f7, imm);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " out_instr"}, out_instr, exp_instr);
    chk({tag, " out_addr"}, out_addr, exp_addr);
    chk({tag, " err_pulse"}, 32'(err_pulse), 32'd0);
    chk({tag, " wrap out_valid"}, 32'(w_out_valid), 32'd1);
    chk({tag, " wrap out_instr"}, w_out_instr, exp_instr);
    chk({tag, " wrap out_addr"}, w_out_addr, exp_waddr);
    exp_addr  = exp_addr + 32'd4;
    exp_waddr = exp_waddr + 32'd4;
  endtask

  task automatic send_bad(input string tag, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
    put(op, rd, rs1, rs2, f3, f7, imm);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    exp_errs = exp_errs + 16'd1;
    chk({tag, " err_pulse"}, 32'(err_pulse), 32'd1);
    chk({tag, " err_count"}, 32'(err_count), 32'(exp_errs));
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " wrap err_pulse"}, 32'(w_err_pulse), 32'd1);
    chk({tag, " wrap err_count"}, 32'(w_err_count), 32'(exp_errs));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  task automatic do_restart(input string tag);
    in_valid = 1'b1;
    restart  = 1'b1;
    #1;
    chk({tag, " in_ready during restart"}, 32'(in_ready), 32'd0);
    chk({tag, " wrap in_ready during restart"}, 32'(w_in_ready), 32'd0);
    step();
    restart  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_instr"}, out_instr, 32'h0);
    chk({tag, " out_addr"}, out_addr, 32'h0);
    chk({tag, " err_count kept"}, 32'(err_count), 32'(exp_errs));
    chk({tag, " err_pulse"}, 32'(err_pulse), 32'd0);
    chk({tag, " wrap out_valid"}, 32'(w_out_valid), 32'd0);
    exp_addr  = 32'h0;
    exp_waddr = 32'hFFFF_FFFC;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_instr", out_instr, 32'h0);
    chk("rst out_addr", out_addr, 32'h0);
    chk("rst err_pulse", 32'(err_pulse), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // First word, then hold it under backpressure
    out_ready = 1'b0;
    send_ok("addi", OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093);
    idle();
    chk("addi hold valid", 32'(out_valid), 32'd1);
    chk("addi hold instr", out_instr, 32'h0050_0093);
    chk("addi hold addr", out_addr, 32'h0);
    out_ready = 1'b1;
    step();
    chk("addi drained", 32'(out_valid), 32'd0);
    do_restart("restart1");

    // Back-to-back with out_ready held high
    out_ready = 1'b1;
    send_ok("sw", OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423);
    send_ok("beq-4", OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3);
    send_ok("jal", OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF);
    send_ok("lui", OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7);
    idle();
    chk("b2b drained", 32'(out_valid), 32'd0);

    // Illegal requests and boundaries
    send_bad("addi 2048", OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send_bad("beq odd", OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    idle();
    chk("err_pulse one cycle", 32'(err_pulse), 32'd0);
    chk("err_count held", 32'(err_count), 32'd2);
    send_ok("addi after err", OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093);
    send_ok("addi -2048", OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093);
    send_ok("add", OP_R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3);
    send_ok("sub", OP_R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h4020_81B3);
    send_ok("beq 4094", OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E00_0FE3);
    send_bad("beq 4096", OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    send_bad("bad opcode", 7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    send_bad("jal 2^20", OP_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
    send_ok("jal -2^20", OP_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 32'h8000_006F);
    send_bad("lui low bits", OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    idle();

    // Backpressure: third request waits until a slot frees
    out_ready = 1'b0;
    put(OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("bp A ready", 32'(in_ready), 32'd1);
    step();
    put(OP_R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
    chk("bp B ready", 32'(in_ready), 32'd1);
    chk("bp head A", out_instr, 32'h0050_0093);
    step();
    put(OP_R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    chk("bp full ready", 32'(in_ready), 32'd0);
    step();
    chk("bp still full", 32'(in_ready), 32'd0);
    chk("bp head stable instr", out_instr, 32'h0050_0093);
    chk("bp head stable addr", out_addr, exp_addr);
    out_ready = 1'b1;
    #1;
    chk("bp full while popping", 32'(in_ready), 32'd0);
    step();
    chk("bp head B", out_instr, 32'h0020_81B3);
    chk("bp addr B", out_addr, exp_addr + 32'd4);
    chk("bp ready after pop", 32'(in_ready), 32'd1);
    step();
    chk("bp head C", out_instr, 32'h4020_81B3);
    chk("bp addr C", out_addr, exp_addr + 32'd8);
    chk("bp wrap addr C", w_out_addr, exp_waddr + 32'd8);
    idle();
    chk("bp drained", 32'(out_valid), 32'd0);
    exp_addr  = exp_addr + 32'd12;
    exp_waddr = exp_waddr + 32'd12;

    // Restart with one word buffered, then wrap on the second instance
    out_ready = 1'b0;
    send_ok("pre-restart", OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7);
    in_valid = 1'b0;
    do_restart("restart2");
    out_ready = 1'b1;
    send_ok("wrap w0", OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093);
    send_ok("wrap w1", OP_R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h0020_81B3);
    idle();

    // Asynchronous reset mid-cycle with a word buffered
    out_ready = 1'b0;
    send_ok("pre-rst", OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst out_instr", out_instr, 32'h0);
    chk("arst out_addr", out_addr, 32'h0);
    chk("arst err_count", 32'(err_count), 32'd0);
    chk("arst err_pulse", 32'(err_pulse), 32'd0);
    chk("arst wrap valid", 32'(w_out_valid), 32'd0);
    chk("arst wrap err_count", 32'(w_err_count), 32'd0);
    step();
    rst = 1'b0;
    exp_addr  = 32'h0;
    exp_waddr = 32'hFFFF_FFFC;
    exp_errs  = 16'h0;
    out_ready = 1'b1;
    send_ok("post-arst", OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093);
    send_bad("post-arst bad", OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_F7FF);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Packs decoded instruction fields and a full 32-bit immediate back into RV32I instruction words; it is the inverse of the immediate generator. It sits on the program-load path, between a test/loader front end and instruction memory. It accepts one request per cycle over a valid/ready handshake and range-checks the immediate for the opcode's format. Legal words leave through a 2-entry output buffer, tagged with an auto-incrementing byte address.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address given to the first emitted word after reset or restart.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- restart  in  1  synchronous; flushes the buffer and reloads the address counter.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_opcode  in  7  one of riscv_pkg OP_* opcodes.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field.
- in_imm  in  32  signed immediate in final (decoded) form; U-type is the already-shifted value.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  consumer takes the head when out_valid && out_ready.
- out_instr  out  32  encoded word.
- out_addr  out  32  byte address of out_instr.
- err_pulse  out  1  one-cycle pulse when an illegal request is consumed.
- err_count  out  16  saturating count of illegal requests.

## Operation
Format selection by opcode:
- I: OP_I_TYPE, OP_LOAD.
- S: OP_STORE.
- B: OP_BRANCH.
- J: OP_JAL.
- U: OP_LUI, OP_AUIPC.
- R: OP_R_TYPE.
- Any other opcode is illegal.

Legality rules (in_imm read as signed):
- I/S: imm in [-2048, 2047].
- B: imm in [-4096, 4094] and imm[0]==0.
- J: imm in [-1048576, 1048574] and imm[0]==0.
- U: imm[11:0]==0.
- R: imm ignored.

Packing:
- I: {imm[11:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- U: {imm[31:12], rd, opcode}.
- R: {funct7, rs2, rs1, funct3, rd, opcode}.
- For I-type shifts the caller supplies funct7 in imm[11:5]; the encoder does no special casing.

Illegal requests:
- Consumed normally (handshake completes).
- Nothing is pushed to the buffer and the address does not advance.
- err_pulse is high in the cycle after acceptance.
- err_count increments and saturates at 16'hFFFF.

Address counter:
- Assigns the current address to each legal word on push, then adds 4.
- Wraps modulo 2^32.

## Timing
Reset (rst high, asynchronous) and restart (synchronous):
- Buffer empty, out_valid=0, out_instr=0, out_addr=0.
- Address counter = BASE_ADDR.
- err_pulse=0.
- err_count=0 on rst only; restart preserves it.

in_ready:
- Registered-free: in_ready = (occupancy < 2) && !restart.
- It does not look at out_ready, so a full buffer blocks input even while the head is popping.

Latency and throughput:
- A legal word accepted at edge N is visible on out_* after edge N; out_valid is high in cycle N+1.
- Sustains 1 word/cycle when out_ready is held high.
- Push and pop in the same cycle at occupancy 1 keeps occupancy at 1, and the next entry becomes the head.

Output stability:
- out_instr and out_addr stay stable while out_valid && !out_ready.
- Order is strictly FIFO.

Priority: rst > restart > push/pop. A request presented in a restart cycle is not accepted.

## Structure
- The riscv_pkg package holds OP_R_TYPE alongside the existing OP_* opcodes, plus an imm_fmt_e enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD}.
- One sub-module, inst_pack: combinational format decode, legality check and bit packing. Outputs are the word and a legal flag.
- The top level holds the handshake, the 2-entry buffer (two registers plus read/write pointers), the address counter and the error counter.

## Test plan
- addi x1,x0,5 (I, funct3=0, imm=5) after reset with BASE_ADDR=0 -> out_instr=0x00500093, out_addr=0, out_valid the cycle after acceptance.
- Back-to-back requests with out_ready=1:
  - sw x2,8(x1) -> 0x0020A423 @0x0.
  - beq x0,x0,-4 -> 0xFE000EE3 @0x4.
  - jal x1,8 -> 0x008000EF @0x8.
  - lui x5,0x12345000 -> 0x123452B7 @0xC.
  - in_ready stays 1 throughout.
- Illegal requests:
  - addi with imm=2048 -> err_pulse one cycle, err_count=1, no output.
  - beq with imm=3 -> err_count=2.
  - The next legal word still gets the un-advanced address.
- Backpressure: hold out_ready=0 and offer 3 requests -> in_ready drops after 2 are accepted and the head stays stable. Release out_ready -> words drain in order and the third request is accepted.
- Address wrap and restart:
  - With BASE_ADDR=32'hFFFF_FFFC, two words are emitted at 0xFFFFFFFC then 0x0.
  - Asserting restart with one word buffered empties the buffer, reloads BASE_ADDR and keeps err_count.
- Asserting rst asynchronously mid-stream -> all outputs and both counters return to their reset values before the next clock edge.
